// File: rtl/mdu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mdu_ctrl_pkg
// Shared parameter header for the multiply/divide unit (the SystemVerilog home
// of the CPU_Param constants). It holds:
//   - the MDU_* op codes, which are defined whether or not the optional
//     accumulate ops are enabled
//   - the default busy latencies for the multiply and divide paths
//   - the controller state type
//   - op classification helpers
// Optional feature macro: MDU_MADD_EN. When it is defined, madd/maddu/msub/msubu
// are real multiply-class ops. When it is not defined, they fall through as
// no-ops.
// ---------------------------------------------------------------------------
package mdu_ctrl_pkg;

    localparam logic [3:0] MDU_none  = 4'd0;
    localparam logic [3:0] MDU_mult  = 4'd1;
    localparam logic [3:0] MDU_multu = 4'd2;
    localparam logic [3:0] MDU_div   = 4'd3;
    localparam logic [3:0] MDU_divu  = 4'd4;
    localparam logic [3:0] MDU_mthi  = 4'd5;
    localparam logic [3:0] MDU_mtlo  = 4'd6;
    localparam logic [3:0] MDU_madd  = 4'd7;
    localparam logic [3:0] MDU_maddu = 4'd8;
    localparam logic [3:0] MDU_msub  = 4'd9;
    localparam logic [3:0] MDU_msubu = 4'd10;

    localparam int MDU_MUL_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    // Multiply-class ops: mult/multu always, plus the accumulate forms when
    // they are built in.
    function automatic logic is_mul_op(input logic [3:0] op);
        logic res;
        res = (op == MDU_mult) || (op == MDU_multu);
`ifdef MDU_MADD_EN
        res = res || (op == MDU_madd) || (op == MDU_maddu) ||
                     (op == MDU_msub) || (op == MDU_msubu);
`endif
        return res;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_div) || (op == MDU_divu);
    endfunction

endpackage

// File: rtl/mdu_ctrl_core.sv
// ---------------------------------------------------------------------------
// mdu_core
// Purely combinational arithmetic for the MDU. It works on the operands and
// op code latched by mdu_ctrl.
// Ports:
//   i_op      latched op code (MDU_* constant)
//   i_a, i_b  latched rs / rt operands
//   i_hi/i_lo current HI/LO, which is the accumulator for madd/msub
//   o_mul_res 64-bit {HI,LO} result of the multiply-class op
//   o_quot    quotient (goes to LO); 0 when the divisor is zero
//   o_rem     remainder (goes to HI); 0 when the divisor is zero
// Optional feature macro: MDU_MADD_EN enables the accumulate/subtract forms.
// ---------------------------------------------------------------------------
module mdu_core
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_mul_res,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem
);

    logic        w_mul_signed;
    logic        w_acc_en;
    logic        w_sub_en;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [63:0] w_prod_signed_dir;

    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;

    assign w_mul_signed = (i_op == MDU_mult) || (i_op == MDU_madd) || (i_op == MDU_msub);

`ifdef MDU_MADD_EN
    assign w_acc_en = (i_op == MDU_madd) || (i_op == MDU_maddu) ||
                      (i_op == MDU_msub) || (i_op == MDU_msubu);
    assign w_sub_en = (i_op == MDU_msub) || (i_op == MDU_msubu);
`else
    assign w_acc_en = 1'b0;
    assign w_sub_en = 1'b0;
`endif

    // The low 64 bits of a 64x64 product of the extended operands give the
    // exact 32x32 product for both signed and unsigned interpretations.
    assign w_a_ext = w_mul_signed ? {{32{i_a[31]}}, i_a} : {32'd0, i_a};
    assign w_b_ext = w_mul_signed ? {{32{i_b[31]}}, i_b} : {32'd0, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_prod_signed_dir = w_sub_en ? (64'd0 - w_prod) : w_prod;
    assign o_mul_res = w_prod_signed_dir + (w_acc_en ? {i_hi, i_lo} : 64'd0);

    // Signed divide goes through magnitudes. The quotient sign is the XOR of
    // the operand signs (truncation toward zero). The remainder follows the
    // dividend. The magnitude of 0x80000000 is still correct as an unsigned
    // value, so the -2^31 / -1 case simply wraps.
    assign w_div_signed = (i_op == MDU_div);
    assign w_a_neg = w_div_signed & i_a[31];
    assign w_b_neg = w_div_signed & i_b[31];
    assign w_a_mag = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag = w_b_neg ? (32'd0 - i_b) : i_b;
    assign w_q_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);
    assign o_quot  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign o_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

endmodule

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl
// Multiply/divide unit controller. It owns the IDLE/MUL/DIV FSM, the latency
// down-counter and the architectural HI/LO registers. The arithmetic itself
// lives in mdu_core.
// Parameters:
//   MUL_CYCLES  busy cycles for the multiply-class ops (must be >= 1)
//   DIV_CYCLES  busy cycles for div/divu (must be >= 1)
// Ports:
//   clk    clock; all state changes on its rising edge
//   reset  synchronous active-high reset
//   Start  an MDU op is issued this cycle
//   MDUOp  op code (MDU_* constant)
//   In0    rs operand
//   In1    rt operand
//   Busy   a multi-cycle op is in flight (registered)
//   HI     architectural HI register
//   LO     architectural LO register
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu.
// ---------------------------------------------------------------------------
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] In0,
    input  logic [31:0] In1,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [3:0]        r_op;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;

    logic [63:0]       w_mul_res;
    logic [31:0]       w_quot;
    logic [31:0]       w_rem;
    logic              w_last;

    mdu_core u_core (
        .i_op      (r_op),
        .i_a       (r_a),
        .i_b       (r_b),
        .i_hi      (r_hi),
        .i_lo      (r_lo),
        .o_mul_res (w_mul_res),
        .o_quot    (w_quot),
        .o_rem     (w_rem)
    );

    // The counter is loaded with the full latency on entry. The edge that
    // sees it at 1 closes the final Busy cycle.
    assign w_last = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_op    <= MDU_none;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        if (is_mul_op(MDUOp)) begin
                            r_op    <= MDUOp;
                            r_a     <= In0;
                            r_b     <= In1;
                            r_cnt   <= CNT_W'(MUL_CYCLES);
                            r_busy  <= 1'b1;
                            r_state <= ST_MUL;
                        end else if (is_div_op(MDUOp)) begin
                            r_op    <= MDUOp;
                            r_a     <= In0;
                            r_b     <= In1;
                            r_cnt   <= CNT_W'(DIV_CYCLES);
                            r_busy  <= 1'b1;
                            r_state <= ST_DIV;
                        end else if (MDUOp == MDU_mthi) begin
                            r_hi <= In0;
                        end else if (MDUOp == MDU_mtlo) begin
                            r_lo <= In0;
                        end
                    end
                end
                // Start is not looked at in the busy states: the pipeline
                // stalls MDU issue while Busy is high.
                ST_MUL: begin
                    if (w_last) begin
                        {r_hi, r_lo} <= w_mul_res;
                        r_cnt        <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (w_last) begin
                        // A zero divisor still takes the full latency, but
                        // HI/LO keep their old values.
                        if (r_b != 32'd0) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_ctrl
// Self-checking bench for mdu_ctrl with its default latencies. A reference
// model of HI/LO is computed with 64-bit integer arithmetic. Each op is
// checked for its Busy length and for the resulting HI/LO.
// ---------------------------------------------------------------------------
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] In0;
    logic [31:0] In1;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl #(.MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDUOp (MDUOp),
        .In0   (In0),
        .In1   (In1),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: the expected busy length, and an update of the
    // model HI/LO.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int cyc);
        longint      sa, sb, q, r;
        logic [63:0] prod;
        cyc = 0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            MDU_mult:  begin cyc = MUL_LAT; prod = 64'(sa * sb); {m_hi, m_lo} = prod; end
            MDU_multu: begin cyc = MUL_LAT; prod = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = prod; end
`ifdef MDU_MADD_EN
            MDU_madd:  begin cyc = MUL_LAT; prod = 64'(sa * sb); {m_hi, m_lo} = {m_hi, m_lo} + prod; end
            MDU_maddu: begin cyc = MUL_LAT; prod = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = {m_hi, m_lo} + prod; end
            MDU_msub:  begin cyc = MUL_LAT; prod = 64'(sa * sb); {m_hi, m_lo} = {m_hi, m_lo} - prod; end
            MDU_msubu: begin cyc = MUL_LAT; prod = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = {m_hi, m_lo} - prod; end
`endif
            MDU_div: begin
                cyc = DIV_LAT;
                if (b != 32'd0) begin
                    q = sa / sb;
                    r = sa - q * sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            MDU_divu: begin
                cyc = DIV_LAT;
                if (b != 32'd0) begin
                    q = longint'({32'd0, a}) / longint'({32'd0, b});
                    r = longint'({32'd0, a}) - q * longint'({32'd0, b});
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            MDU_mthi: m_hi = a;
            MDU_mtlo: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op and measure how long Busy stays high. With scramble set,
    // the operands are changed and a mult Start is raised during Busy; both
    // must be ignored.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit scramble);
        int exp_cyc;
        int n;
        @(negedge clk);
        Start = 1'b1; MDUOp = op; In0 = a; In1 = b;
        model_op(op, a, b, exp_cyc);
        @(negedge clk);
        Start = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            if (scramble) begin
                In0 = $urandom; In1 = $urandom; Start = 1'b1; MDUOp = MDU_mult;
            end
            @(negedge clk);
        end
        Start = 1'b0;
        $display("op %s code=%0d a=%h b=%h busy=%0d HI=%h LO=%h", tag, op, a, b, n, HI, LO);
        check({tag, "_busy"}, 64'(n), 64'(exp_cyc));
        check({tag, "_hilo"}, {HI, LO}, {m_hi, m_lo});
    endtask

    initial begin
        int dummy;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1; Start = 1'b0; MDUOp = MDU_none; In0 = '0; In1 = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);

        do_op("mult", MDU_mult, 32'hFFFFFFFE, 32'd3, 1'b0);
        check("mult_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
        do_op("multu", MDU_multu, 32'hFFFFFFFE, 32'd3, 1'b0);
        check("multu_const", {HI, LO}, 64'h00000002_FFFFFFFA);
        do_op("div", MDU_div, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        do_op("divu0", MDU_divu, 32'd7, 32'd0, 1'b0);
        check("divu0_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        do_op("mthi", MDU_mthi, 32'h1234, 32'd0, 1'b0);
        check("mthi_const", 64'(HI), 64'h1234);
        do_op("mult_scr", MDU_mult, 32'd1000, 32'hFFFFFFFF, 1'b1);
        check("mult_scr_const", {HI, LO}, 64'hFFFFFFFF_FFFFFC18);
        do_op("div_scr", MDU_div, 32'd100, 32'hFFFFFFF9, 1'b1);
        do_op("divmin", MDU_div, 32'h80000000, 32'hFFFFFFFF, 1'b0);

        // Accumulate form starting from HI=0, LO=0xFFFFFFFF.
        do_op("mthi0", MDU_mthi, 32'd0, 32'd0, 1'b0);
        do_op("mtlo", MDU_mtlo, 32'hFFFFFFFF, 32'd0, 1'b0);
        do_op("madd", MDU_madd, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
        check("madd_const", {HI, LO}, 64'h00000001_00000000);
`else
        check("madd_const", {HI, LO}, 64'h00000000_FFFFFFFF);
`endif

        // Reset during DIV cycle 4 discards the op and clears HI/LO.
        do_op("mtlo_pre", MDU_mtlo, 32'h5555AAAA, 32'd0, 1'b0);
        @(negedge clk);
        Start = 1'b1; MDUOp = MDU_divu; In0 = 32'd99; In1 = 32'd4;
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        check("div_c4_busy", 64'(Busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        $display("op reset_mid_div busy=%0d HI=%h LO=%h", Busy, HI, LO);
        check("rst_mid_busy", 64'(Busy), 64'd0);
        check("rst_mid_hilo", {HI, LO}, 64'd0);

        // Start coincident with reset is dropped.
        do_op("mthi_pre", MDU_mthi, 32'hCAFE, 32'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1; Start = 1'b1; MDUOp = MDU_mult; In0 = 32'd3; In1 = 32'd3;
        @(negedge clk);
        reset = 1'b0; Start = 1'b0;
        m_hi = '0; m_lo = '0;
        $display("op reset_with_start busy=%0d HI=%h LO=%h", Busy, HI, LO);
        check("rst_start_busy", 64'(Busy), 64'd0);
        check("rst_start_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        check("rst_start_busy2", 64'(Busy), 64'd0);

        // Random ops, including undefined codes and zero divisors.
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 1) == 0) rb = rb >> $urandom_range(0, 31);
            do_op("rand", rop, ra, rb, ($urandom_range(0, 1) == 1));
        end
        dummy = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
